// File: rtl/microsequencer.sv
// -----------------------------------------------------------------------------
// microsequencer
//
// Control-unit microsequencer for the ARM simulator core. Holds the current
// microaddress (index), presents it to the combinational microstore and
// computes the next microaddress from the returned microword's sequencing
// fields, the decoder dispatch address and datapath conditions.
//
// Microword sequencing fields:
//   CR = mw_in[6:0]   literal address
//   CS = mw_in[9:7]   condition select
//   NS = mw_in[12:10] next-address select
// Every other microword bit belongs to the datapath and is ignored here.
//
// Configuration macro: MICROSEQ_CALL_STACK_EN
//   defined   : return stack, call (NS=110), return (NS=101) and stack_err
//   undefined : no stack storage; NS 101/110 increment; stack_err tied to 0
//
// Parameters:
//   STACK_DEPTH  return-stack entries (power of two, 2..8)
//   RESET_ADDR   microaddress after reset and after a return on an empty stack
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   reset_n    in   asynchronous active-low reset
//   mw_in      in   [44:0] microword for the current index
//   dec_addr   in   [6:0]  dispatch address from the instruction decoder
//   flags      in   [3:0]  NZCV, [3]=N [2]=Z [1]=C [0]=V
//   cond_pass  in   ARM condition-field evaluation result
//   moc        in   memory operation complete
//   halt       in   freeze sequencing (index, stack and stack_err hold)
//   index      out  [6:0]  current microaddress
//   wait_moc   out  stalled on a memory wait (combinational)
//   stack_err  out  sticky return-stack overflow/underflow flag
// -----------------------------------------------------------------------------
module microsequencer #(
  parameter int unsigned STACK_DEPTH = 4,
  parameter logic [6:0]  RESET_ADDR  = 7'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [44:0] mw_in,
  input  logic [6:0]  dec_addr,
  input  logic [3:0]  flags,
  input  logic        cond_pass,
  input  logic        moc,
  input  logic        halt,
  output logic [6:0]  index,
  output logic        wait_moc,
  output logic        stack_err
);

  // Stack pointer carries one extra bit so "full" (== STACK_DEPTH) is
  // distinguishable from "empty" (== 0).
  localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned SP_W  = PTR_W + 1;

  typedef enum logic [2:0] {
    NS_INC   = 3'b000,
    NS_JUMP  = 3'b001,
    NS_DISP  = 3'b010,
    NS_COND  = 3'b011,
    NS_WAIT  = 3'b100,
    NS_RET   = 3'b101,
    NS_CALL  = 3'b110,
    NS_FETCH = 3'b111
  } ns_e;

  // Condition multiplexer selected by CS.
  function automatic logic cond_select(
    input logic [2:0] cs,
    input logic       moc_b,
    input logic       pass_b,
    input logic [3:0] nzcv
  );
    logic t;
    case (cs)
      3'b000:  t = 1'b1;
      3'b001:  t = moc_b;
      3'b010:  t = pass_b;
      3'b011:  t = nzcv[3];
      3'b100:  t = nzcv[2];
      3'b101:  t = nzcv[1];
      3'b110:  t = nzcv[0];
      3'b111:  t = 1'b0;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  logic [6:0] index_q;
  logic [6:0] index_d;
  logic [6:0] cr_s;
  logic [2:0] cs_s;
  ns_e        ns_s;
  logic [6:0] inc_s;
  logic       cond_t_s;

  assign cr_s     = mw_in[6:0];
  assign cs_s     = mw_in[9:7];
  assign ns_s     = ns_e'(mw_in[12:10]);
  assign inc_s    = index_q + 7'd1;  // 7-bit add wraps 127 -> 0
  assign cond_t_s = cond_select(cs_s, moc, cond_pass, flags);

`ifdef MICROSEQ_CALL_STACK_EN
  logic [6:0]      stack_q [STACK_DEPTH];
  logic [SP_W-1:0] sp_q;
  logic [SP_W-1:0] sp_d;
  logic            err_q;
  logic            err_d;
  logic            push_s;
  logic [SP_W-1:0] sp_dec_s;
  logic [6:0]      top_s;
  logic            full_s;
  logic            empty_s;
  logic            unused_mw_s;

  assign unused_mw_s = ^mw_in[44:13];
  assign sp_dec_s    = sp_q - {{(SP_W-1){1'b0}}, 1'b1};
  assign top_s       = stack_q[sp_dec_s[PTR_W-1:0]];
  assign full_s      = (sp_q == SP_W'(STACK_DEPTH));
  assign empty_s     = (sp_q == {SP_W{1'b0}});

  // Next microaddress, stack pointer and error flag.
  always_comb begin
    index_d = index_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push_s  = 1'b0;
    if (halt) begin
      // Frozen: everything holds.
      index_d = index_q;
    end else begin
      case (ns_s)
        NS_INC:  index_d = inc_s;
        NS_JUMP: index_d = cr_s;
        NS_DISP: index_d = dec_addr;
        NS_COND: begin
          if (cond_t_s) begin
            index_d = cr_s;
          end else begin
            index_d = inc_s;
          end
        end
        NS_WAIT: begin
          if (moc) begin
            index_d = inc_s;
          end else begin
            index_d = index_q;
          end
        end
        NS_RET: begin
          if (empty_s) begin
            // Underflow restarts the fetch sequence.
            index_d = RESET_ADDR;
            err_d   = 1'b1;
          end else begin
            index_d = top_s;
            sp_d    = sp_dec_s;
          end
        end
        NS_CALL: begin
          // The jump is taken even when the return address cannot be saved.
          index_d = cr_s;
          if (full_s) begin
            err_d = 1'b1;
          end else begin
            push_s = 1'b1;
            sp_d   = sp_q + {{(SP_W-1){1'b0}}, 1'b1};
          end
        end
        NS_FETCH: index_d = RESET_ADDR;
        default:  index_d = inc_s;
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index_q <= RESET_ADDR;
      sp_q    <= {SP_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      index_q <= index_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  // Return-address storage; the entry written here is the one the next
  // cycle's return reads, so call-then-return works back to back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        stack_q[i] <= 7'd0;
      end
    end else if (push_s) begin
      stack_q[sp_q[PTR_W-1:0]] <= inc_s;
    end else begin
      stack_q <= stack_q;
    end
  end

  assign stack_err = err_q;

`else
  logic unused_cfg_s;

  // Stack-less build: STACK_DEPTH only sizes storage that is not built.
  assign unused_cfg_s = ^{mw_in[44:13], SP_W'(STACK_DEPTH)};

  // Next microaddress; call and return degrade to increment.
  always_comb begin
    index_d = index_q;
    if (halt) begin
      index_d = index_q;
    end else begin
      case (ns_s)
        NS_INC:  index_d = inc_s;
        NS_JUMP: index_d = cr_s;
        NS_DISP: index_d = dec_addr;
        NS_COND: begin
          if (cond_t_s) begin
            index_d = cr_s;
          end else begin
            index_d = inc_s;
          end
        end
        NS_WAIT: begin
          if (moc) begin
            index_d = inc_s;
          end else begin
            index_d = index_q;
          end
        end
        NS_RET:   index_d = inc_s;
        NS_CALL:  index_d = inc_s;
        NS_FETCH: index_d = RESET_ADDR;
        default:  index_d = inc_s;
      endcase
    end
  end

  // Microaddress register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index_q <= RESET_ADDR;
    end else begin
      index_q <= index_d;
    end
  end

  assign stack_err = 1'b0;
`endif

  assign index    = index_q;
  assign wait_moc = (ns_s == NS_WAIT) & ~moc & ~halt;

endmodule

// File: tb/tb_microsequencer.sv
// -----------------------------------------------------------------------------
// tb_microsequencer
//
// Self-checking bench for microsequencer. The bench plays the role of the
// microstore by driving mw_in directly. A behavioural model (integer index,
// queue as return stack) predicts index, stack_err and wait_moc each cycle;
// directed sequences pin both the DUT and the model to literal addresses,
// followed by randomized sequencing and a mid-run asynchronous reset.
// Build with or without MICROSEQ_CALL_STACK_EN to match the RTL.
// -----------------------------------------------------------------------------
module tb_microsequencer;

  localparam int         DEPTH = 4;
  localparam logic [6:0] RST_A = 7'd0;
`ifdef MICROSEQ_CALL_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [44:0] mw_in;
  logic [6:0]  dec_addr;
  logic [3:0]  flags;
  logic        cond_pass;
  logic        moc;
  logic        halt;
  logic [6:0]  index;
  logic        wait_moc;
  logic        stack_err;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state.
  int exp_idx = 0;
  int stk[$];
  bit exp_err = 1'b0;

  microsequencer #(.STACK_DEPTH(DEPTH), .RESET_ADDR(RST_A)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mw_in     (mw_in),
    .dec_addr  (dec_addr),
    .flags     (flags),
    .cond_pass (cond_pass),
    .moc       (moc),
    .halt      (halt),
    .index     (index),
    .wait_moc  (wait_moc),
    .stack_err (stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Pin DUT and model to a hand-computed address.
  task automatic pin(input string nm, input int lit);
    chk({"lit_", nm}, int'(index), lit);
    chk({"mdl_", nm}, exp_idx, lit);
  endtask

  function automatic logic [44:0] mkmw(input int ns, input int cs, input int cr);
    logic [44:0] w;
    w        = 45'({$urandom(), $urandom()});  // datapath bits are noise
    w[12:10] = 3'(ns);
    w[9:7]   = 3'(cs);
    w[6:0]   = 7'(cr);
    return w;
  endfunction

  // Next-state rules of the sequencer, applied at a rising edge.
  function automatic void model_step(input logic [44:0] mw);
    int cr, cs, ns, nxt;
    bit tv[8];
    cr = int'(mw[6:0]);
    cs = int'(mw[9:7]);
    ns = int'(mw[12:10]);
    tv[0] = 1'b1;    tv[1] = moc;      tv[2] = cond_pass; tv[3] = flags[3];
    tv[4] = flags[2]; tv[5] = flags[1]; tv[6] = flags[0];  tv[7] = 1'b0;
    if (halt) return;
    nxt = (exp_idx + 1) % 128;
    case (ns)
      0: exp_idx = nxt;
      1: exp_idx = cr;
      2: exp_idx = int'(dec_addr);
      3: exp_idx = tv[cs] ? cr : nxt;
      4: exp_idx = moc ? nxt : exp_idx;
      5: begin
        if (!STK) exp_idx = nxt;
        else if (stk.size() == 0) begin
          exp_idx = int'(RST_A);
          exp_err = 1'b1;
        end else exp_idx = stk.pop_back();
      end
      6: begin
        if (!STK) exp_idx = nxt;
        else begin
          if (stk.size() == DEPTH) exp_err = 1'b1;
          else stk.push_back(nxt);
          exp_idx = cr;
        end
      end
      default: exp_idx = int'(RST_A);
    endcase
  endfunction

  // One microinstruction: drive at the falling edge, check wait_moc before
  // the rising edge and index/stack_err just after it.
  task automatic op(input int ns, input int cs, input int cr, input logic [6:0] da,
                    input logic [3:0] f, input logic cp, input logic m, input logic h);
    logic [44:0] w;
    w = mkmw(ns, cs, cr);
    mw_in = w; dec_addr = da; flags = f; cond_pass = cp; moc = m; halt = h;
    #1;
    chk("wait_moc", int'(wait_moc), int'((ns == 4) && !m && !h));
    @(posedge clk);
    model_step(w);
    #1;
    chk("index", int'(index), exp_idx);
    chk("stack_err", int'(stack_err), int'(exp_err));
    @(negedge clk);
  endtask

  task automatic jmp(input int a);
    op(1, 0, a, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic rand_ops(input int n);
    for (int i = 0; i < n; i++) begin
      op($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 127),
         7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    mw_in = 45'd0; dec_addr = 7'd0; flags = 4'd0;
    cond_pass = 1'b0; moc = 1'b0; halt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_index", int'(index), 0);
    chk("rst_err", int'(stack_err), 0);
    chk("rst_wait_moc", int'(wait_moc), 0);  // NS=000 in mw_in
    reset_n = 1'b1;

    // Increment wrap and jump.
    jmp('h7F);                                   pin("jmp_7f", 'h7F);
    op(0, 0, 'h33, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0); pin("wrap", 'h00);
    jmp('h51);                                   pin("jmp_51", 'h51);

    // Dispatch and conditional on Z.
    op(2, 0, 'h11, 7'h28, 4'd0, 1'b0, 1'b1, 1'b0); pin("disp", 'h28);
    jmp('h05);
    op(3, 4, 'h10, 7'd0, 4'b0100, 1'b0, 1'b1, 1'b0); pin("cond_z1", 'h10);
    jmp('h05);
    op(3, 4, 'h10, 7'd0, 4'b1011, 1'b0, 1'b1, 1'b0); pin("cond_z0", 'h06);

    // Memory wait: three stalled cycles then completion.
    jmp('h09);
    for (int i = 0; i < 3; i++) begin
      mw_in = mkmw(4, 0, 0); moc = 1'b0; halt = 1'b0;
      #1;
      chk("lit_wait_moc_hi", int'(wait_moc), 1);
      @(negedge clk);
      op(4, 0, 0, 7'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      pin("wait_hold", 'h09);
    end
    op(4, 0, 0, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0);   pin("wait_done", 'h0A);

    // Halt overrides a jump.
    op(1, 0, 'h33, 7'd0, 4'd0, 1'b0, 1'b1, 1'b1); pin("halt", 'h0A);

`ifdef MICROSEQ_CALL_STACK_EN
    jmp('h12);
    op(6, 0, 'h40, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0); pin("call", 'h40);
    op(5, 0, 'h00, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0); pin("ret", 'h13);
    for (int i = 0; i < 5; i++) begin
      op(6, 0, 'h60 + i, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0);
      if (i == 3) chk("lit_err_before_ovf", int'(stack_err), 0);
    end
    pin("ovf_jump", 'h64);
    chk("lit_err_ovf", int'(stack_err), 1);
    op(5, 0, 0, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0);   pin("pop1", 'h63);
    op(5, 0, 0, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0);   pin("pop2", 'h62);
    op(5, 0, 0, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0);   pin("pop3", 'h61);
    op(5, 0, 0, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0);   pin("pop4", 'h14);
    op(5, 0, 0, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0);   pin("pop_empty", 'h00);
`else
    jmp('h20);
    op(6, 0, 'h55, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0); pin("call_nostack", 'h21);
    chk("lit_err_nostack", int'(stack_err), 0);
    op(5, 0, 'h55, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0); pin("ret_nostack", 'h22);
`endif

    rand_ops(3000);

    // Asynchronous reset mid-run, away from any clock edge.
    jmp('h2A);                                   pin("pre_reset", 'h2A);
    op(6, 0, 'h2A, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("lit_async_rst_index", int'(index), 0);
    chk("lit_async_rst_err", int'(stack_err), 0);
    exp_idx = int'(RST_A);
    exp_err = 1'b0;
    stk.delete();
    @(negedge clk);
    reset_n = 1'b1;
`ifdef MICROSEQ_CALL_STACK_EN
    jmp('h30);
    op(5, 0, 0, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0);   pin("ret_after_rst", 'h00);
    chk("lit_err_after_rst_pop", int'(stack_err), 1);
`else
    op(0, 0, 0, 7'd0, 4'd0, 1'b0, 1'b1, 1'b0);   pin("inc_after_rst", 'h01);
`endif

    rand_ops(500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
